// File: rtl/agc_pkg.sv
// Shared FSM state type, derived widths and code helpers for the AGC stream controller.
package agc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    UPDATE = 2'd2
  } agc_state_t;

  function automatic int cnt_w(input int win_len);
    return (win_len > 1) ? $clog2(win_len) : 1;
  endfunction

  function automatic int num_w(input int data_w, input int frac_w);
    return data_w + frac_w;
  endfunction

  function automatic int prod_w(input int data_w, input int gain_w);
    return data_w + gain_w + 1;
  endfunction

  function automatic int mid_code(input int data_w);
    return 1 << (data_w - 1);
  endfunction

  // Clamp a signed value into the unsigned code range [0, 2^data_w-1].
  function automatic int sat_code(input longint value, input int data_w);
    longint top;
    top = (longint'(1) << data_w) - 1;
    if (value < 0) return 0;
    if (value > top) return int'(top);
    return int'(value);
  endfunction

endpackage

// File: rtl/agc_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; the first bit is resolved
// in the start cycle so the quotient is final exactly NUM_W cycles after start.
module agc_divider #(
  parameter int NUM_W = 16,
  parameter int DEN_W = 8
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic [NUM_W-1:0] quot,
  output logic             done
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] rem_reg, rem_next, rem_in;
  logic [NUM_W-1:0] quo_reg, quo_next, quo_in;
  logic [DEN_W-1:0] den_reg, den_in;
  logic [CNT_W-1:0] cnt_reg;
  logic             done_reg;
  logic [DEN_W:0]   trial, diff;
  logic             fits;

  // The borrow bit of trial-den tells whether the divisor fits.
  always_comb begin
    rem_in   = start ? '0  : rem_reg;
    quo_in   = start ? num : quo_reg;
    den_in   = start ? den : den_reg;
    trial    = {rem_in, quo_in[NUM_W-1]};
    diff     = trial - {1'b0, den_in};
    fits     = ~diff[DEN_W];
    rem_next = fits ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
    quo_next = {quo_in[NUM_W-2:0], fits};
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      den_reg  <= '0;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        den_reg <= den;
        cnt_reg <= CNT_W'(NUM_W - 1);
      end else if (cnt_reg != '0) begin
        rem_reg  <= rem_next;
        quo_reg  <= quo_next;
        cnt_reg  <= cnt_reg - CNT_W'(1);
        done_reg <= (cnt_reg == CNT_W'(1));
      end
    end
  end

  assign quot = quo_reg;
  assign done = done_reg;

endmodule

// File: rtl/agc_stream_ctrl.sv
// Automatic gain control between ADC capture and DAC drive: windowed peak tracking,
// divider-based target gain, step-limited gain updates and a saturating scale pipeline.
module agc_stream_ctrl
  import agc_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int WIN_LEN   = 500,
  parameter int TARGET    = 36,
  parameter int FRAC_W    = 8,
  parameter int GAIN_W    = 12,
  parameter int GAIN_INIT = 256,
  parameter int MAX_STEP  = 16
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] adc_in,
  input  logic              hold,
  output logic [DATA_W-1:0] dac_out,
  output logic              dac_valid,
  output logic [GAIN_W-1:0] gain_out,
  output logic [DATA_W-1:0] peak_out,
  output logic              gain_upd,
  output logic              busy
);

  localparam int MID      = mid_code(DATA_W);
  localparam int CNT_W    = cnt_w(WIN_LEN);
  localparam int NUM_W    = num_w(DATA_W, FRAC_W);
  localparam int PROD_W   = prod_w(DATA_W, GAIN_W);
  localparam int GAIN_MAX = (1 << GAIN_W) - 1;
  localparam int TGT_W    = (NUM_W > GAIN_W) ? NUM_W : GAIN_W;
  localparam int STEP_W   = $clog2(MAX_STEP + 1);
  localparam int CMP_W    = ((TGT_W > STEP_W) ? TGT_W : STEP_W) + 2;

  localparam logic signed [DATA_W:0]   MID_S   = (DATA_W + 1)'(MID);
  localparam logic signed [PROD_W-1:0] MID_P   = PROD_W'(MID);
  localparam logic [NUM_W-1:0]         DIV_NUM = NUM_W'(TARGET) << FRAC_W;
  localparam logic [CMP_W-1:0]         STEP_C  = CMP_W'(MAX_STEP);
  localparam logic [CMP_W-1:0]         GMAX_C  = CMP_W'(GAIN_MAX);

  logic signed [DATA_W:0]   s_val;
  logic [DATA_W:0]          s_abs;
  logic [DATA_W-1:0]        mag, pk;
  logic signed [PROD_W-1:0] prod_next, prod_reg, y_val;
  logic [DATA_W-1:0]        dac_next, dac_reg;
  logic                     v1_reg, dac_valid_reg;
  logic [DATA_W-1:0]        acc_reg, peak_reg;
  logic [CNT_W-1:0]         win_cnt_reg;
  logic                     win_close;

  agc_state_t               state_reg, state_next;
  logic [TGT_W-1:0]         tgt_reg, tgt_next;
  logic [GAIN_W-1:0]        gain_reg, gain_next, step_gain;
  logic                     gain_upd_reg, gain_upd_next;
  logic [CMP_W-1:0]         tgt_cmp, g_cmp;
  logic                     div_start, div_done;
  logic [NUM_W-1:0]         div_quot;

  // A full-scale negative sample has magnitude MID, one above what DATA_W-1 bits hold.
  always_comb begin
    s_val     = $signed({1'b0, adc_in}) - MID_S;
    s_abs     = s_val[DATA_W] ? unsigned'(-s_val) : unsigned'(s_val);
    mag       = (s_abs >= (DATA_W + 1)'(MID)) ? DATA_W'(MID - 1) : s_abs[DATA_W-1:0];
    pk        = (mag > acc_reg) ? mag : acc_reg;
    win_close = sample_en && (win_cnt_reg == CNT_W'(WIN_LEN - 1));
    prod_next = PROD_W'(s_val) * PROD_W'($signed({1'b0, gain_reg}));
    y_val     = (prod_reg >>> FRAC_W) + MID_P;
    dac_next  = DATA_W'(sat_code(longint'(y_val), DATA_W));
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      prod_reg      <= '0;
      v1_reg        <= 1'b0;
      dac_reg       <= DATA_W'(MID);
      dac_valid_reg <= 1'b0;
      acc_reg       <= '0;
      peak_reg      <= '0;
      win_cnt_reg   <= '0;
    end else begin
      v1_reg        <= sample_en;
      dac_valid_reg <= v1_reg;
      if (sample_en) prod_reg <= prod_next;
      if (v1_reg) dac_reg <= dac_next;
      if (sample_en) begin
        if (win_close) begin
          peak_reg    <= pk;
          acc_reg     <= '0;
          win_cnt_reg <= '0;
        end else begin
          acc_reg     <= pk;
          win_cnt_reg <= win_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  agc_divider #(
    .NUM_W (NUM_W),
    .DEN_W (DATA_W)
  ) u_divider (
    .clkin (clkin),
    .rst   (rst),
    .start (div_start),
    .num   (DIV_NUM),
    .den   (pk),
    .quot  (div_quot),
    .done  (div_done)
  );

  // Move toward the clamped target by at most MAX_STEP.
  always_comb begin
    tgt_cmp = (CMP_W'(tgt_reg) > GMAX_C) ? GMAX_C : CMP_W'(tgt_reg);
    g_cmp   = CMP_W'(gain_reg);
    if (tgt_cmp > g_cmp + STEP_C)
      step_gain = GAIN_W'(g_cmp + STEP_C);
    else if (tgt_cmp + STEP_C < g_cmp)
      step_gain = GAIN_W'(g_cmp - STEP_C);
    else
      step_gain = GAIN_W'(tgt_cmp);
  end

  always_comb begin
    state_next    = state_reg;
    tgt_next      = tgt_reg;
    gain_next     = gain_reg;
    gain_upd_next = 1'b0;
    div_start     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_close) begin
          if (pk == '0) begin
            tgt_next   = TGT_W'(GAIN_MAX);
            state_next = UPDATE;
          end else begin
            div_start  = 1'b1;
            state_next = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (div_done) begin
          tgt_next   = TGT_W'(div_quot);
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        state_next = IDLE;
        if (!hold) begin
          gain_next     = step_gain;
          gain_upd_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      tgt_reg      <= '0;
      gain_reg     <= GAIN_W'(GAIN_INIT);
      gain_upd_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tgt_reg      <= tgt_next;
      gain_reg     <= gain_next;
      gain_upd_reg <= gain_upd_next;
    end
  end

  assign dac_out   = dac_reg;
  assign dac_valid = dac_valid_reg;
  assign gain_out  = gain_reg;
  assign peak_out  = peak_reg;
  assign gain_upd  = gain_upd_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_agc_stream_ctrl.sv
// Randomized bench for agc_stream_ctrl: two instances (unlimited and limited gain step)
// share one stimulus stream and are compared every cycle against a timestamp-based model.
module tb_agc_stream_ctrl;

  localparam int NCYC = 1500;
  localparam int WL   = 8;
  localparam int GMAX = 4095;

  logic       clkin     = 1'b0;
  logic       rst       = 1'b1;
  logic       sample_en = 1'b0;
  logic       hold      = 1'b0;
  logic [7:0] adc_in    = 8'd128;

  logic [7:0]  dac_o      [2];
  logic        dac_valid_o[2];
  logic [11:0] gain_o     [2];
  logic [7:0]  peak_o     [2];
  logic        gain_upd_o [2];
  logic        busy_o     [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clkin = ~clkin;

  agc_stream_ctrl #(
    .DATA_W(8), .WIN_LEN(WL), .TARGET(36), .FRAC_W(8),
    .GAIN_W(12), .GAIN_INIT(256), .MAX_STEP(4095)
  ) dut_a (
    .clkin(clkin), .rst(rst), .sample_en(sample_en), .adc_in(adc_in), .hold(hold),
    .dac_out(dac_o[0]), .dac_valid(dac_valid_o[0]), .gain_out(gain_o[0]),
    .peak_out(peak_o[0]), .gain_upd(gain_upd_o[0]), .busy(busy_o[0])
  );

  agc_stream_ctrl #(
    .DATA_W(8), .WIN_LEN(WL), .TARGET(36), .FRAC_W(8),
    .GAIN_W(12), .GAIN_INIT(256), .MAX_STEP(16)
  ) dut_b (
    .clkin(clkin), .rst(rst), .sample_en(sample_en), .adc_in(adc_in), .hold(hold),
    .dac_out(dac_o[1]), .dac_valid(dac_valid_o[1]), .gain_out(gain_o[1]),
    .peak_out(peak_o[1]), .gain_upd(gain_upd_o[1]), .busy(busy_o[1])
  );

  int step_m[2] = '{4095, 16};
  int gain_m[2], peak_m[2], acc_m[2], cnt_m[2];
  int busy_lo[2], busy_hi[2], pend_t[2], pend_tgt[2], exp_dac[2];
  int y_hist[2][NCYC];
  bit en_hist[NCYC];
  bit hold_hist[NCYC];
  int sp[6] = '{255, 0, 128, 146, 110, 200};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Ideal output: floor((adc-mid)*gain/256)+mid, clipped to the 8-bit code range.
  function automatic int scale(input int a, input int g);
    int v, q;
    v = (a - 128) * g;
    q = (v >= 0) ? v / 256 : -((-v + 255) / 256);
    q = q + 128;
    if (q < 0) q = 0;
    if (q > 255) q = 255;
    return q;
  endfunction

  function automatic int next_gain(input int g, input int tgt, input int step);
    int tc;
    tc = (tgt > GMAX) ? GMAX : tgt;
    if (tc > g + step) return g + step;
    if (tc + step < g) return g - step;
    return tc;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      gain_m[i]  = 256;
      peak_m[i]  = 0;
      acc_m[i]   = 0;
      cnt_m[i]   = 0;
      busy_lo[i] = -10;
      busy_hi[i] = -10;
      pend_t[i]  = -1;
      pend_tgt[i] = 0;
      exp_dac[i] = 128;
    end
  endtask

  // A sample strobed in cycle t; a window close starts a computation only if idle.
  task automatic model_sample(input int i, input int t, input int a);
    int mag, pk;
    y_hist[i][t] = scale(a, gain_m[i]);
    mag = (a >= 128) ? a - 128 : 128 - a;
    if (mag > 127) mag = 127;
    pk = (mag > acc_m[i]) ? mag : acc_m[i];
    cnt_m[i]++;
    if (cnt_m[i] == WL) begin
      peak_m[i] = pk;
      acc_m[i]  = 0;
      cnt_m[i]  = 0;
      if (!(t >= busy_lo[i] && t <= busy_hi[i])) begin
        busy_lo[i] = t + 1;
        if (pk == 0) begin
          busy_hi[i]  = t + 1;
          pend_t[i]   = t + 2;
          pend_tgt[i] = GMAX;
        end else begin
          busy_hi[i]  = t + 17;
          pend_t[i]   = t + 18;
          pend_tgt[i] = (36 * 256) / pk;
        end
      end
    end else begin
      acc_m[i] = pk;
    end
  endtask

  initial begin : main
    bit aborted;
    bit e, h, r;
    int a, amp, upd_e, val_e, busy_e;
    aborted = 1'b0;
    model_reset();
    for (int t = 0; t < NCYC; t++) begin
      @(negedge clkin);
      if (t > 0) begin
        for (int i = 0; i < 2; i++) begin
          upd_e = 0;
          if (pend_t[i] == t) begin
            if (!hold_hist[t-1]) begin
              gain_m[i] = next_gain(gain_m[i], pend_tgt[i], step_m[i]);
              upd_e = 1;
            end
            pend_t[i] = -1;
          end
          val_e = (t >= 2 && en_hist[t-2]) ? 1 : 0;
          if (val_e != 0) exp_dac[i] = y_hist[i][t-2];
          busy_e = (t >= busy_lo[i] && t <= busy_hi[i]) ? 1 : 0;
          check($sformatf("dut%0d.dac_out", i), int'(dac_o[i]), exp_dac[i]);
          check($sformatf("dut%0d.dac_valid", i), int'(dac_valid_o[i]), val_e);
          check($sformatf("dut%0d.gain_out", i), int'(gain_o[i]), gain_m[i]);
          check($sformatf("dut%0d.peak_out", i), int'(peak_o[i]), peak_m[i]);
          check($sformatf("dut%0d.gain_upd", i), int'(gain_upd_o[i]), upd_e);
          check($sformatf("dut%0d.busy", i), int'(busy_o[i]), busy_e);
          if (gain_upd_o[i])
            $display("t=%0d dut%0d gain_upd gain=%0d peak=%0d", t, i, gain_o[i], peak_o[i]);
        end
      end

      r = (t == 0) || (t == 7) ||
          (!aborted && t >= 600 && t < 900 && (busy_hi[0] - busy_lo[0] == 16) && t == busy_lo[0] + 4);
      if (r) begin
        if (t >= 600) aborted = 1'b1;
        rst = 1'b1;
        sample_en = 1'b0;
        hold = 1'b0;
        en_hist[t] = 1'b0;
        hold_hist[t] = 1'b0;
        if (t > 0) en_hist[t-1] = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
          check($sformatf("dut%0d.rst_dac_out", i), int'(dac_o[i]), 128);
          check($sformatf("dut%0d.rst_dac_valid", i), int'(dac_valid_o[i]), 0);
          check($sformatf("dut%0d.rst_gain_out", i), int'(gain_o[i]), 256);
          check($sformatf("dut%0d.rst_peak_out", i), int'(peak_o[i]), 0);
          check($sformatf("dut%0d.rst_gain_upd", i), int'(gain_upd_o[i]), 0);
          check($sformatf("dut%0d.rst_busy", i), int'(busy_o[i]), 0);
        end
        model_reset();
      end else begin
        e = 1'b0;
        a = 128;
        h = 1'b0;
        if (t < 10) begin
          e = (t >= 1 && t <= 6);
          case (t)
            1, 2:    a = 200;
            3:       a = 255;
            4:       a = 0;
            5:       a = 128;
            default: a = 60;
          endcase
        end else if (t < 300) begin
          e = (t % 4 == 0);
          if (t < 260) a = (cnt_m[0] == 3) ? 146 : int'($urandom_range(110, 146));
          else a = sp[$urandom_range(0, 5)];
        end else if (t < 600) begin
          e = (t % 2 == 0);
          a = 128;
          h = (t >= 450);
        end else if (t < 900) begin
          e = 1'b1;
          amp = 1 + (t / 40) % 60;
          a = 128 - amp + int'($urandom_range(0, 2 * amp));
          h = ($urandom_range(0, 3) == 0);
        end else begin
          e = ($urandom_range(0, 1) == 1);
          a = int'($urandom_range(0, 255));
          h = ($urandom_range(0, 7) == 0);
        end
        rst = 1'b0;
        sample_en = e;
        adc_in = 8'(a);
        hold = h;
        en_hist[t] = e;
        hold_hist[t] = h;
        if (e) begin
          for (int i = 0; i < 2; i++) model_sample(i, t, a);
        end
      end
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
